// File: rtl/shift_unit_seq_pkg.sv
// Shared types and constants for the iterative shift unit.
// The ALU opcode encodings are the ones the shiftless ALUs already use.
// Only the three shift opcodes are legal requests for the shift unit.
package shift_unit_seq_pkg;

    localparam int SHAMT_W = 5;

    localparam logic [3:0] alu_op_add  = 4'd0;
    localparam logic [3:0] alu_op_sub  = 4'd1;
    localparam logic [3:0] alu_op_and  = 4'd2;
    localparam logic [3:0] alu_op_or   = 4'd3;
    localparam logic [3:0] alu_op_xor  = 4'd4;
    localparam logic [3:0] alu_op_sll  = 4'd5;
    localparam logic [3:0] alu_op_srl  = 4'd6;
    localparam logic [3:0] alu_op_sra  = 4'd7;
    localparam logic [3:0] alu_op_slt  = 4'd8;
    localparam logic [3:0] alu_op_sltu = 4'd9;

    typedef enum logic [1:0] {
        SHU_IDLE,
        SHU_BUSY,
        SHU_DONE
    } shu_state_e;

    // True for the opcodes this unit serves.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == alu_op_sll) || (op == alu_op_srl) || (op == alu_op_sra);
    endfunction

endpackage

// File: rtl/shift_unit_seq_if.sv
// Request/response bundle of the shift unit, including the synchronous flush.
// master drives requests and consumes responses; slave is the shift unit.
interface shift_unit_seq_if #(
    parameter int TAG_W = 4
) ();
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_aluop;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_f;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;

    modport master (
        output flush, req_valid, req_aluop, req_a, req_b, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_f, resp_tag, resp_err
    );

    modport slave (
        input  flush, req_valid, req_aluop, req_a, req_b, req_tag, resp_ready,
        output req_ready, resp_valid, resp_f, resp_tag, resp_err
    );
endinterface

// File: rtl/shift_unit_seq_shift_step.sv
// Combinational single-step shifter used by shift_unit_seq.
// SRA is done on the signed view so bit 31 is replicated; applied repeatedly
// it keeps the sign bit of the original operand.
module shift_step
    import shift_unit_seq_pkg::*;
(
    input  logic [31:0]        data,
    input  logic [3:0]         op,
    input  logic [SHAMT_W-1:0] amt,
    output logic [31:0]        result
);

    // Shift the word by amt in the direction selected by op; other ops pass through.
    always_comb begin
        result = data;
        case (op)
            alu_op_sll: result = data << amt;
            alu_op_srl: result = data >> amt;
            alu_op_sra: result = 32'($signed(data) >>> amt);
            default:    result = data;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Iterative sequential shifter for SLL/SRL/SRA with valid/ready request and response.
// Consumes STEP_BITS bits of the shift amount per BUSY cycle; one request in flight.
// Optional feature macro: SHIFT_UNIT_EARLY_DONE_EN finishes as soon as the
// remaining unconsumed shift-amount bits are all zero.
module shift_unit_seq
    import shift_unit_seq_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter int STEP_BITS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_unit_seq_if.slave    bus
);

    localparam int N_STEPS = (SHAMT_W + STEP_BITS - 1) / STEP_BITS;
    localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

    shu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        data_q, data_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [3:0]         op_q, op_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               err_q, err_d;

    logic               accept;
    logic               req_legal;
    logic               last_step;
    logic [SHAMT_W-1:0] step_mask;
    logic [SHAMT_W-1:0] step_amt;
    logic [31:0]        step_out;
    logic               unused_req_b_hi;

    assign unused_req_b_hi = ^bus.req_b[31:SHAMT_W];

    // Request accept qualifier and per-step shift amount for the current chunk.
    always_comb begin
        accept    = (state_q == SHU_IDLE) && bus.req_valid && !bus.flush;
        req_legal = is_shift_op(bus.req_aluop);
        last_step = (int'(count_q) == N_STEPS - 1);
        step_mask = SHAMT_W'(((1 << STEP_BITS) - 1) << (int'(count_q) * STEP_BITS));
        step_amt  = shamt_q & step_mask;
    end

`ifdef SHIFT_UNIT_EARLY_DONE_EN
    logic rest_zero;

    // Shift-amount bits not yet consumed once the current step has been applied.
    always_comb begin
        rest_zero = ((shamt_q >> ((int'(count_q) + 1) * STEP_BITS)) == '0);
    end
`endif

    shift_step u_step (
        .data   (data_q),
        .op     (op_q),
        .amt    (step_amt),
        .result (step_out)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SHU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SHU_IDLE: begin
                if (accept) begin
`ifdef SHIFT_UNIT_EARLY_DONE_EN
                    if (req_legal && (bus.req_b[SHAMT_W-1:0] != '0)) begin
                        state_d = SHU_BUSY;
                    end else begin
                        state_d = SHU_DONE;
                    end
`else
                    state_d = req_legal ? SHU_BUSY : SHU_DONE;
`endif
                end
            end
            SHU_BUSY: begin
`ifdef SHIFT_UNIT_EARLY_DONE_EN
                if (last_step || rest_zero) begin
                    state_d = SHU_DONE;
                end
`else
                if (last_step) begin
                    state_d = SHU_DONE;
                end
`endif
            end
            SHU_DONE: begin
                if (bus.resp_ready) begin
                    state_d = SHU_IDLE;
                end
            end
            default: state_d = SHU_IDLE;
        endcase
        if (bus.flush) begin
            state_d = SHU_IDLE;
        end
    end

    // Operand capture on accept and one shift step per BUSY cycle.
    always_comb begin
        count_d = count_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        tag_d   = tag_q;
        err_d   = err_q;
        if (accept) begin
            count_d = '0;
            data_d  = req_legal ? bus.req_a : 32'd0;
            shamt_d = bus.req_b[SHAMT_W-1:0];
            op_d    = bus.req_aluop;
            tag_d   = bus.req_tag;
            err_d   = !req_legal;
        end else if ((state_q == SHU_BUSY) && !bus.flush) begin
            data_d  = step_out;
            count_d = count_q + 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs; a flush hides a finished result in the same cycle.
    always_comb begin
        bus.req_ready  = (state_q == SHU_IDLE);
        bus.resp_valid = (state_q == SHU_DONE) && !bus.flush;
        bus.resp_f     = data_q;
        bus.resp_tag   = tag_q;
        bus.resp_err   = err_q;
    end

endmodule
